// File: rtl/nibble_chain_adder.sv
// Sequential nibble front/back end for an external 4-bit adder: chains the carry across WORDS nibbles.
// Optional signed-overflow output out_ovf is enabled by defining NIBBLE_CHAIN_OVF_EN.
module nibble_chain_adder #(
   parameter int WORDS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in_a,
   input  logic [3:0] in_b,
   input  logic       in_first,
   input  logic       in_cin,
   output logic [3:0] add_a,
   output logic [3:0] add_b,
   output logic       add_cin,
   input  logic [3:0] add_sum,
   input  logic       add_cout,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [3:0] out_sum,
   output logic       out_last,
   output logic       out_cout,
`ifdef NIBBLE_CHAIN_OVF_EN
   output logic       out_ovf,
`endif
   output logic       seq_err
);

   localparam int IDX_W = (WORDS > 2) ? $clog2(WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

   typedef enum logic [0:0] {
      ST_FIRST = 1'b0,
      ST_CHAIN = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             cy_q, cy_d;
   logic             out_valid_q, out_valid_d;
   logic [3:0]       out_sum_q, out_sum_d;
   logic             out_last_q, out_last_d;
   logic             out_cout_q, out_cout_d;
   logic             seq_err_q, seq_err_d;
`ifdef NIBBLE_CHAIN_OVF_EN
   logic             out_ovf_q, out_ovf_d;
`endif

   logic             start_s;
   logic [IDX_W-1:0] eff_idx_s;
   logic             is_last_s;
   logic             fire_s;

   // A nibble restarts the chain when idle or when the producer flags a new operand.
   assign start_s   = (state_q == ST_FIRST) | in_first;
   assign eff_idx_s = start_s ? '0 : idx_q;
   assign is_last_s = (eff_idx_s == LAST_IDX);

   assign in_ready  = ~out_valid_q | out_ready;
   assign fire_s    = in_valid & in_ready;

   assign add_a     = in_a;
   assign add_b     = in_b;
   assign add_cin   = start_s ? in_cin : cy_q;

   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_last  = out_last_q;
   assign out_cout  = out_cout_q;
   assign seq_err   = seq_err_q;
`ifdef NIBBLE_CHAIN_OVF_EN
   assign out_ovf   = out_ovf_q;
`endif

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cy_d        = cy_q;
      out_valid_d = out_valid_q;
      out_sum_d   = out_sum_q;
      out_last_d  = out_last_q;
      out_cout_d  = out_cout_q;
      seq_err_d   = 1'b0;
`ifdef NIBBLE_CHAIN_OVF_EN
      out_ovf_d   = out_ovf_q;
`endif
      if (fire_s) begin
         out_valid_d = 1'b1;
         out_sum_d   = add_sum;
         out_last_d  = is_last_s;
         out_cout_d  = is_last_s ? add_cout : 1'b0;
         seq_err_d   = in_first & (state_q == ST_CHAIN);
`ifdef NIBBLE_CHAIN_OVF_EN
         // Sign bits of the top nibble decide overflow of the whole-width add.
         out_ovf_d   = is_last_s & (in_a[3] == in_b[3]) & (add_sum[3] != in_a[3]);
`endif
         case (is_last_s)
            1'b1: begin
               idx_d   = '0;
               cy_d    = 1'b0;
               state_d = ST_FIRST;
            end
            1'b0: begin
               idx_d   = eff_idx_s + IDX_W'(1);
               cy_d    = add_cout;
               state_d = ST_CHAIN;
            end
            default: begin
               idx_d   = '0;
               cy_d    = 1'b0;
               state_d = ST_FIRST;
            end
         endcase
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_FIRST;
         idx_q       <= '0;
         cy_q        <= 1'b0;
         out_valid_q <= 1'b0;
         out_sum_q   <= 4'h0;
         out_last_q  <= 1'b0;
         out_cout_q  <= 1'b0;
         seq_err_q   <= 1'b0;
`ifdef NIBBLE_CHAIN_OVF_EN
         out_ovf_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cy_q        <= cy_d;
         out_valid_q <= out_valid_d;
         out_sum_q   <= out_sum_d;
         out_last_q  <= out_last_d;
         out_cout_q  <= out_cout_d;
         seq_err_q   <= seq_err_d;
`ifdef NIBBLE_CHAIN_OVF_EN
         out_ovf_q   <= out_ovf_d;
`endif
      end
   end

endmodule

// File: tb/tb_nibble_chain_adder.sv
// Scoreboard bench for nibble_chain_adder with a behavioural 4-bit adder on the add_* ports.
module tb_nibble_chain_adder;

   localparam int WORDS = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] in_a = 4'h0;
   logic [3:0] in_b = 4'h0;
   logic       in_first = 1'b0;
   logic       in_cin = 1'b0;
   logic [3:0] add_a, add_b, add_sum;
   logic       add_cin, add_cout;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [3:0] out_sum;
   logic       out_last, out_cout, seq_err;
`ifdef NIBBLE_CHAIN_OVF_EN
   logic       out_ovf;
`endif

   typedef struct packed {
      logic [3:0] sum;
      logic       last;
      logic       cout;
      logic       ovf;
   } exp_t;

   exp_t exp_q[$];
   int   n_total = 0;
   int   n_bad   = 0;
   int   pos     = 0;

   nibble_chain_adder #(.WORDS(WORDS)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_first(in_first), .in_cin(in_cin),
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
      .add_sum(add_sum), .add_cout(add_cout),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_last(out_last), .out_cout(out_cout),
`ifdef NIBBLE_CHAIN_OVF_EN
      .out_ovf(out_ovf),
`endif
      .seq_err(seq_err)
   );

   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0000, add_cin};

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
      n_total++;
      if (got !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, expv);
      end
   endtask

   // Consumer side: a transfer completes at the next rising edge whenever valid & ready here.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_out", 32'(out_sum), 32'hDEAD);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("out_sum", 32'(out_sum), 32'(e.sum));
            chk("out_last", 32'(out_last), 32'(e.last));
            chk("out_cout", 32'(out_cout), 32'(e.cout));
`ifdef NIBBLE_CHAIN_OVF_EN
            chk("out_ovf", 32'(out_ovf), 32'(e.ovf));
`endif
         end
      end
   end

   task automatic send_nib(input logic [3:0] a, input logic [3:0] b, input logic first,
                           input logic cin, input exp_t e);
      int  n;
      int  eff;
      logic exp_seq;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_first = first;
      in_cin   = cin;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) begin
         chk("in_ready_timeout", 32'(in_ready), 32'd1);
         @(posedge clk);
         #1;
         in_valid = 1'b0;
      end else begin
         exp_q.push_back(e);
         exp_seq = first && (pos != 0);
         eff = (first || pos == 0) ? 0 : pos;
         pos = (eff == WORDS - 1) ? 0 : eff + 1;
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         chk("seq_err", 32'(seq_err), 32'(exp_seq));
      end
   endtask

   task automatic send_word(input logic [15:0] a, input logic [15:0] b, input logic cin,
                            input logic use_first, input int n_nibs, input int stall_after);
      logic [16:0] full;
      exp_t e;
      full = {1'b0, a} + {1'b0, b} + {16'h0000, cin};
      for (int k = 0; k < n_nibs; k++) begin
         e.sum  = full[4*k +: 4];
         e.last = (k == WORDS - 1);
         e.cout = e.last ? full[16] : 1'b0;
         e.ovf  = e.last ? ((a[15] == b[15]) && (full[15] != a[15])) : 1'b0;
         send_nib(a[4*k +: 4], b[4*k +: 4], (k == 0) && use_first, cin, e);
         if (k == stall_after) begin
            out_ready = 1'b0;
            for (int s = 0; s < 3; s++) begin
               @(negedge clk);
               chk("stall_in_ready", 32'(in_ready), 32'd0);
               chk("stall_out_valid", 32'(out_valid), 32'd1);
               chk("stall_out_sum", 32'(out_sum), 32'(e.sum));
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #3;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_sum", 32'(out_sum), 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
      chk("rst_out_cout", 32'(out_cout), 32'd0);
      chk("rst_seq_err", 32'(seq_err), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;

      send_word(16'h0000, 16'h0001, 1'b0, 1'b0, 4, -1);
      send_word(16'hFFFF, 16'h0001, 1'b0, 1'b1, 4, -1);
      send_word(16'h1234, 16'h0000, 1'b1, 1'b1, 4, -1);
      send_word(16'h000F, 16'h0001, 1'b0, 1'b1, 4, -1);
      send_word(16'hFFFF, 16'h0001, 1'b0, 1'b1, 4, 1);

      // Restart mid-chain: partial operand abandoned after two nibbles.
      send_word(16'h0505, 16'h0303, 1'b0, 1'b1, 2, -1);
      send_word(16'h0007, 16'h0001, 1'b0, 1'b1, 4, -1);
      @(posedge clk);
      #1;
      chk("seq_err_one_pulse", 32'(seq_err), 32'd0);

      send_word(16'h7FFF, 16'h0001, 1'b0, 1'b1, 4, -1);
      send_word(16'h8000, 16'h8000, 1'b0, 1'b1, 4, -1);
      for (int r = 0; r < 4; r++) begin
         logic [15:0] ra, rb;
         ra = 16'($urandom);
         rb = 16'($urandom);
         send_word(ra, rb, 1'($urandom_range(1, 0)), 1'b1, 4, -1);
      end

      // Asynchronous reset in the middle of a chain.
      send_word(16'h1111, 16'h2222, 1'b1, 1'b1, 2, -1);
      rst = 1'b1;
      #1;
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_out_sum", 32'(out_sum), 32'd0);
      chk("mid_rst_out_last", 32'(out_last), 32'd0);
      chk("mid_rst_out_cout", 32'(out_cout), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      exp_q.delete();
      pos = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      send_word(16'h0001, 16'h0002, 1'b1, 1'b0, 4, -1);

      repeat (4) @(posedge clk);
      #1;
      chk("drain", 32'(exp_q.size()), 32'd0);
      chk("idle_out_valid", 32'(out_valid), 32'd0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
